// File: rtl/ir_sample_seq_if.sv
// Sensor-sequencer bus: enable in, A2D handshake, IR emitter enable and the published 8-sensor frame.
// Latency: none, plain wires.
// Backpressure: none; the A2D side answers each strt_cnv with exactly one cnv_cmplt.
interface ir_sample_seq_if;
  logic        en;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        IR_en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
  logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
  logic        IR_vld;
  logic        ovr;

  // Sequencer side
  modport master (
    input  en, cnv_cmplt, res,
    output IR_en, strt_cnv, chnnl,
    output IR_R0, IR_R1, IR_R2, IR_R3,
    output IR_L0, IR_L1, IR_L2, IR_L3,
    output IR_vld, ovr
  );

  // Environment side (A2D converter, enable source, frame consumer)
  modport slave (
    output en, cnv_cmplt, res,
    input  IR_en, strt_cnv, chnnl,
    input  IR_R0, IR_R1, IR_R2, IR_R3,
    input  IR_L0, IR_L1, IR_L2, IR_L3,
    input  IR_vld, ovr
  );
endinterface

// File: rtl/ir_sample_seq.sv
// Sensor-frame sequencer: IR emitter timing, 8-channel A2D scan, double-buffered frame publish.
// Latency: frame lands 1 + SETTLE_CYC + sum(1 + A2D latency) + 1 cycles after the period tick (inclusive).
// Backpressure: none; a tick arriving while a frame is in flight is dropped and sets the sticky ovr flag.
module ir_sample_seq #(
  parameter logic [19:0] PERIOD_CYC = 20'd1000000,
  parameter logic [15:0] SETTLE_CYC = 16'd4096,
  parameter int          CNT_W      = 20
) (
  input logic             clk,
  input logic             rst_n,
  ir_sample_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Terminal values of the period and settle counters (SETTLE_CYC must be at least 1).
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 20'd1);
  localparam logic [15:0]      SETTLE_LAST = SETTLE_CYC - 16'd1;
  localparam logic [2:0]       K_LAST      = 3'd7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stl_q, stl_d;
  logic [2:0]       k_q, k_d;
  logic             tick;
  logic             cap;       // store res into working register k this cycle
  logic             last_cap;  // capture of channel 7: frame complete
  logic             ovr_set;

  // Working registers fill during the scan; frame_q is what the consumer sees.
  // Index k maps even -> IR_R(k/2), odd -> IR_L(k/2).
  logic [11:0] work_q  [8];
  logic [11:0] frame_q [8];

  logic       ir_en_q;
  logic       strt_q;
  logic       vld_q;
  logic       ovr_q;
  logic [2:0] chnnl_q;

  // Period counter next value: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    tick  = bus.en && (cnt_q == PERIOD_LAST);
    cnt_d = '0;
    if (bus.en && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Scan FSM next state, settle counter, channel index and capture strobes.
  always_comb begin
    state_d  = state_q;
    stl_d    = stl_q;
    k_d      = k_q;
    cap      = 1'b0;
    last_cap = 1'b0;
    // Any tick outside IDLE (DONE included) is an overrun; the running frame is left alone.
    ovr_set  = tick && (state_q != IDLE);
    if (!bus.en) begin
      // Abort: working data is abandoned, published frame is untouched.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d = SETTLE;
            stl_d   = '0;
            k_d     = '0;
          end
        end
        SETTLE: begin
          if (stl_q == SETTLE_LAST) begin
            state_d = CONV;
          end else begin
            stl_d = stl_q + 16'd1;
          end
        end
        CONV: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.cnv_cmplt) begin
            cap = 1'b1;
            if (k_q == K_LAST) begin
              last_cap = 1'b1;
              state_d  = DONE;
            end else begin
              k_d     = k_q + 3'd1;
              state_d = CONV;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stl_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stl_q   <= stl_d;
      k_q     <= k_d;
    end
  end

  // Working buffer: one slot per channel, written as each conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        work_q[i] <= '0;
      end
    end else if (cap) begin
      work_q[k_q] <= bus.res;
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_en_q <= 1'b0;
      strt_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      chnnl_q <= '0;
    end else begin
      ir_en_q <= (state_d == SETTLE) || (state_d == CONV) || (state_d == WAIT);
      strt_q  <= (state_d == CONV);
      vld_q   <= (state_d == DONE);
      chnnl_q <= k_d;
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

  // Frame publish: loaded on entry to DONE so the new frame and IR_vld appear together.
  // Channel 7 is taken straight from res since its working slot is written on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        frame_q[i] <= '0;
      end
    end else if (last_cap) begin
      for (int i = 0; i < 7; i++) begin
        frame_q[i] <= work_q[i];
      end
      frame_q[7] <= bus.res;
    end
  end

  assign bus.IR_en    = ir_en_q;
  assign bus.strt_cnv = strt_q;
  assign bus.chnnl    = chnnl_q;
  assign bus.IR_vld   = vld_q;
  assign bus.ovr      = ovr_q;
  assign bus.IR_R0    = frame_q[0];
  assign bus.IR_L0    = frame_q[1];
  assign bus.IR_R1    = frame_q[2];
  assign bus.IR_L1    = frame_q[3];
  assign bus.IR_R2    = frame_q[4];
  assign bus.IR_L2    = frame_q[5];
  assign bus.IR_R3    = frame_q[6];
  assign bus.IR_L3    = frame_q[7];

endmodule

// File: tb/tb_ir_sample_seq.sv
// Bench for ir_sample_seq: A2D responder, event-time reference model, directed phases then random traffic.
// Latency: outputs are compared every cycle on the falling clock edge.
// Backpressure: none modelled; the A2D responder replies once per start pulse.
module tb_ir_sample_seq;
  localparam int P = 64;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ir_sample_seq_if bus ();

  ir_sample_seq #(
    .PERIOD_CYC(20'd64),
    .SETTLE_CYC(16'd8),
    .CNT_W     (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [11:0] dout [8];
  assign dout[0] = bus.IR_R0;
  assign dout[1] = bus.IR_L0;
  assign dout[2] = bus.IR_R1;
  assign dout[3] = bus.IR_L1;
  assign dout[4] = bus.IR_R2;
  assign dout[5] = bus.IR_L2;
  assign dout[6] = bus.IR_R3;
  assign dout[7] = bus.IR_L3;
  string out_nm [8];

  int n_chk = 0;
  int n_err = 0;
  int t = 0;

  // Reference model: period counter plus event times of the frame in flight.
  int          m_cnt;
  bit          m_busy;     // emitter on, frame in progress
  int          m_strt_at;  // cycle in which the current conversion start is due
  int          m_vld_at;   // cycle in which the frame is published
  int          m_k;
  logic [2:0]  m_ch;
  bit          m_ovr;
  logic [11:0] m_work [8];
  logic [11:0] m_out  [8];

  // Environment controls and observations
  bit         en_drv;
  int         lat;
  bit         rnd_res;
  bit         spur;
  int         a2d_due;
  logic [2:0] a2d_ch;
  int         vld_seen, strt_seen, vld_t;
  int         ir_rise, first_strt;
  logic [2:0] first_ch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_busy = 0; m_strt_at = -1; m_vld_at = -1; m_k = 0; m_ch = '0; m_ovr = 0;
    for (int i = 0; i < 8; i++) begin
      m_work[i] = '0;
      m_out[i]  = '0;
    end
    a2d_due = -1;
  endtask

  // One cycle at the falling edge: compare, observe, drive inputs, advance the model.
  task automatic body();
    bit          tick, waiting, cmplt;
    logic [11:0] r;
    chk("IR_en",    32'(bus.IR_en),    32'(m_busy));
    chk("strt_cnv", 32'(bus.strt_cnv), 32'(m_busy && (t == m_strt_at)));
    chk("chnnl",    32'(bus.chnnl),    32'(m_ch));
    chk("IR_vld",   32'(bus.IR_vld),   32'(t == m_vld_at));
    chk("ovr",      32'(bus.ovr),      32'(m_ovr));
    for (int i = 0; i < 8; i++) chk(out_nm[i], 32'(dout[i]), 32'(m_out[i]));

    if (bus.IR_en && ir_rise < 0) ir_rise = t;
    if (bus.strt_cnv) begin
      strt_seen++;
      a2d_due = t + lat;
      a2d_ch  = bus.chnnl;
      if (first_strt < 0) begin
        first_strt = t;
        first_ch   = bus.chnnl;
      end
    end
    if (bus.IR_vld) begin
      vld_seen++;
      vld_t = t;
    end

    waiting = m_busy && (t > m_strt_at);
    cmplt   = 1'b0;
    r       = 12'($urandom);
    if (t == a2d_due) begin
      cmplt = 1'b1;
      r     = rnd_res ? 12'($urandom) : (12'h100 + 12'(a2d_ch));
    end else if (spur && !waiting && ($urandom_range(0, 5) == 0)) begin
      cmplt = 1'b1;
      r     = 12'hFFF;
    end
    bus.en        = en_drv;
    bus.cnv_cmplt = cmplt;
    bus.res       = r;

    tick  = en_drv && (m_cnt == P - 1);
    m_cnt = (!en_drv || tick) ? 0 : m_cnt + 1;
    if (!en_drv) begin
      m_busy = 0;
    end else begin
      if (tick) begin
        if (m_busy || (t == m_vld_at)) m_ovr = 1;
        else begin
          m_busy = 1; m_k = 0; m_ch = '0; m_strt_at = t + 1 + S;
        end
      end
      if (waiting && cmplt) begin
        m_work[m_k] = r;
        if (m_k == 7) begin
          m_busy   = 0;
          m_vld_at = t + 1;
          for (int i = 0; i < 8; i++) m_out[i] = m_work[i];
        end else begin
          m_k++;
          m_ch      = 3'(m_k);
          m_strt_at = t + 1;
        end
      end
    end
    t++;
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  task automatic run_until_vld(input int n, input int budget, input string tag);
    int c = 0;
    while (vld_seen < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 32'(vld_seen), 32'(n));
  endtask

  initial begin
    int c, base_t, off_left;
    out_nm = '{"IR_R0", "IR_L0", "IR_R1", "IR_L1", "IR_R2", "IR_L2", "IR_R3", "IR_L3"};
    rst_n = 1'b0;
    bus.en = 1'b0; bus.cnv_cmplt = 1'b0; bus.res = '0;
    en_drv = 1; lat = 3; rnd_res = 0; spur = 0;
    vld_seen = 0; strt_seen = 0; vld_t = -1; ir_rise = -1; first_strt = -1; first_ch = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    body();

    // Frame 1: fixed A2D latency 3, res = 0x100 + channel
    run_until_vld(1, 300, "frame1_done");
    chk("ir_en_rise", 32'(ir_rise), 32'(P));
    chk("settle_gap", 32'(first_strt - ir_rise), 32'(S));
    chk("frame1_strts", 32'(strt_seen), 32'd8);
    chk("frame1_latency", 32'(vld_t - (ir_rise - 1) + 1), 32'(1 + S + 8 * (1 + lat) + 1));
    for (int i = 0; i < 8; i++) chk({out_nm[i], "_f1"}, 32'(dout[i]), 32'(12'h100 + i));

    // Frame 2: random data, previous frame must hold until publish
    rnd_res = 1;
    run_until_vld(2, 200, "frame2_done");

    // Overrun: A2D latency 10 makes a frame longer than the period
    lat = 10; vld_seen = 0;
    run_until_vld(2, 600, "overrun_frames");
    chk("ovr_sticky", 32'(bus.ovr), 32'd1);

    // Asynchronous reset during SETTLE
    lat = 3; c = 0;
    while (!(m_busy && t < m_strt_at - 2) && c < 200) begin step(); c++; end
    chk("reach_settle", 32'(m_busy && t < m_strt_at - 2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_IR_en", 32'(bus.IR_en), 32'd0);
    chk("arst_ovr",   32'(bus.ovr),   32'd0);
    for (int i = 0; i < 8; i++) chk({out_nm[i], "_arst"}, 32'(dout[i]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    base_t = t; ir_rise = -1; vld_seen = 0;
    body();
    run_until_vld(1, 300, "post_reset_frame");
    chk("ir_en_rise_after_rst", 32'(ir_rise - base_t), 32'(P));

    // en dropped in the WAIT of k=4; its completion arrives while idle
    c = 0;
    while (!(m_busy && m_k == 4 && t > m_strt_at) && c < 300) begin step(); c++; end
    chk("reach_wait_k4", 32'(m_busy && m_k == 4 && t > m_strt_at), 32'd1);
    en_drv = 0; vld_seen = 0;
    repeat (20) step();
    chk("no_vld_on_abort", 32'(vld_seen), 32'd0);
    en_drv = 1; first_strt = -1; strt_seen = 0;
    run_until_vld(1, 300, "restart_frame");
    chk("restart_k0", 32'(first_ch), 32'd0);
    chk("restart_strts", 32'(strt_seen), 32'd8);

    // Random traffic: variable latency, stray completions, occasional enable drops
    spur = 1; vld_seen = 0; off_left = 0;
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 6);
      if (off_left > 0) begin
        off_left--;
        if (off_left == 0) en_drv = 1;
      end else if ($urandom_range(0, 599) == 0) begin
        off_left = $urandom_range(1, 40);
        en_drv   = 0;
      end
      step();
    end
    chk("random_frames", 32'(vld_seen > 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule

// File: doc/ir_sample_seq.md
Name: ir_sample_seq

Overview:
Sequencer that owns the IR emitter and the shared 8-channel A2D converter and produces the sensor frame consumed by the error-computation block. Once per sample period it enables the IR emitters, waits for optical settling, then converts the eight sensors one at a time. It double-buffers the results and publishes a complete, coherent frame (IR_R0..IR_R3, IR_L0..IR_L3) with a one-cycle IR_vld pulse. It also flags frame overruns.

Parameters:
PERIOD_CYC, 20'd1000000, sample period in clk cycles (frame start rate)
SETTLE_CYC, 16'd4096, cycles IR_en is held high before the first conversion
CNT_W, 20, width of the period counter (must hold PERIOD_CYC-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sequencer enable; low = idle and abort
cnv_cmplt  input  1  A2D conversion-complete pulse
res  input  12  A2D result, valid while cnv_cmplt=1
IR_en  output  1  IR emitter enable
strt_cnv  output  1  one-cycle A2D start pulse
chnnl  output  3  A2D channel select
IR_R0..IR_R3  output  12 each  right sensor readings, inside to outside
IR_L0..IR_L3  output  12 each  left sensor readings, inside to outside
IR_vld  output  1  one-cycle pulse: new frame is on the IR_* outputs
ovr  output  1  sticky overrun flag

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). Reset clears all flops: IR_en=0, strt_cnv=0, chnnl=0, all IR_*=0, IR_vld=0, ovr=0, state=IDLE, counters=0. All outputs are registered.
- Period counter: free-runs 0..PERIOD_CYC-1 while en=1 and wraps to 0. tick=1 when count==PERIOD_CYC-1. en=0 holds the counter at 0.
- Conversion index k (0..7): chnnl=k. Even k maps to IR_R(k/2); odd k maps to IR_L(k/2). Order is R0,L0,R1,L1,R2,L2,R3,L3.
- FSM states are IDLE, SETTLE, CONV, WAIT, DONE.
  - IDLE: IR_en=0. On tick with en=1, go to SETTLE and clear the settle counter and k.
  - SETTLE: IR_en=1. After SETTLE_CYC cycles, go to CONV.
  - CONV: strt_cnv=1 for exactly this one cycle, with chnnl=k. Next state is WAIT.
  - WAIT: chnnl is held. cnv_cmplt in the cycle right after CONV is still valid. On cnv_cmplt, write res into working register k.
    - If k==7, go to DONE.
    - Otherwise increment k and go to CONV.
  - DONE: copy all 8 working registers to the IR_* outputs. IR_vld=1 for this single cycle. IR_en=0. Next state is IDLE.
- IR_en stays high from SETTLE entry through the final WAIT, including that WAIT's capture cycle.
- Outputs change only in DONE. The downstream block never sees a mixed frame. Values persist between frames.
- Frame latency from tick: 1 + SETTLE_CYC + sum over the 8 conversions of (1 + A2D latency) + 1 cycles to IR_vld.
- Overrun: tick while state!=IDLE sets ovr=1 and the tick is dropped. The current frame continues. ovr clears only on reset.
- en falling mid-frame: next cycle the FSM goes to IDLE with IR_en=0 and strt_cnv=0. The working data is discarded, there is no IR_vld, and the outputs keep the previous frame. A cnv_cmplt arriving later in IDLE is ignored.
- cnv_cmplt outside WAIT is ignored.
- Reset asserted mid-frame clears everything immediately, including IR_en.

Test Plan:
- PERIOD_CYC=64, SETTLE_CYC=8, A2D model replies after 3 cycles with res=12'h100+chnnl; en=1 from reset -> IR_en rises the cycle after count 63. First strt_cnv comes 8 cycles later. Eight strt_cnv pulses with chnnl 0..7. One IR_vld pulse; IR_R0=100, IR_L0=101, IR_R1=102, IR_L1=103, IR_R2=104, IR_L2=105, IR_R3=106, IR_L3=107 (hex).
- Output stability -> every IR_* output holds its previous frame value during frame 2 until the DONE cycle. Output values are checked every cycle.
- A2D latency 10 cycles with PERIOD_CYC=64 -> the frame overruns. ovr=1 after the tick lands in WAIT. The frame still completes with one IR_vld, and the next frame starts on the following tick. ovr remains 1.
- en dropped during the WAIT of k=4, then cnv_cmplt arrives -> IR_en=0 next cycle. No IR_vld. Outputs keep the prior frame. Re-enable -> a full fresh frame with k starting at 0.
- rst_n pulsed low during SETTLE -> all outputs are 0 asynchronously (before the next clk edge). After release, the first frame starts PERIOD_CYC cycles later.
- cnv_cmplt injected in IDLE and SETTLE with res=12'hFFF -> no register changes and no state change.
